sl_tx_sched: RTL
================

Name: sl_tx_sched

Overview:
Round-robin scheduler that shares one serial-line (SL) bit-level transmit engine among NREQ word requesters.
- Accepts words with per-request length over a valid/ready handshake.
- Launches each word to the engine with a start pulse and supervises it to completion or timeout.
- Enforces a minimum idle gap on the line between words.
- Reports per-word completion status back to the requesters.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 32, word data width; fixed at 32 in this design
GAP_CYC, 64, minimum clk cycles between tx_done/tx_err and the next tx_start
TIMEOUT_CYC, 4096, max clk cycles from tx_start to tx_done/tx_err before abort

Ports:
clk  in  1  system clock, 16 MHz
rst_n  in  1  reset, synchronous, active-low
enable  in  1  scheduler enable; when low, no new grants are made and an in-flight word completes
req_valid  in  NREQ  per-requester word available
req_data  in  NREQ*32  packed words; requester i uses bits [32i+31:32i]
req_len  in  NREQ*6  packed word lengths in bits; requester i uses bits [6i+5:6i]
req_ready  out  NREQ  one-hot, single-cycle pulse: word accepted
tx_start  out  1  single-cycle launch pulse to the engine
tx_data  out  32  word to send, LSB first; stable from tx_start until done
tx_len  out  6  bit count to send; stable from tx_start until done
tx_busy  in  1  engine busy
tx_done  in  1  engine single-cycle pulse: word plus stop bit sent
tx_err  in  1  engine single-cycle pulse: line level error, word aborted
grant_id  out  clog2(NREQ)  id of the currently or last granted requester
done_valid  out  1  single-cycle completion pulse
done_id  out  clog2(NREQ)  requester id for done_valid
done_err  out  2  status: 0 ok, 1 bad length, 2 engine error, 3 timeout
sched_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: every output is 0. State is IDLE. Round-robin pointer last_grant = NREQ-1, so requester 0 wins first. Counters are 0.
- rst_n low mid-word: return to IDLE next edge with tx_start=0 and no done_valid. The engine shares rst_n.
- All outputs are registered.
- States:
  - IDLE → GRANT when enable=1, at least one req_valid bit is set, and tx_busy=0. The winner is the first set req_valid scanning from last_grant+1 modulo NREQ. Latch grant_id in the same edge.
  - GRANT, 1 cycle:
    - req_ready[grant_id]=1; capture that requester's data and length; last_grant ← grant_id.
    - If the length is in 8..32 → LAUNCH.
    - Otherwise → REPORT with done_err=1; no tx_start and no gap.
  - LAUNCH, 1 cycle: tx_start=1, tx_data/tx_len driven from the captured registers. Clear the timeout counter. → WAIT.
  - WAIT: the timeout counter increments every cycle.
    - tx_done → REPORT with err 0.
    - Else tx_err → REPORT with err 2.
    - Else counter reaches TIMEOUT_CYC-1 → REPORT with err 3.
    - tx_done and tx_err in the same cycle: tx_err wins, err 2.
  - REPORT, 1 cycle: done_valid=1 with done_id=grant_id and done_err as latched.
    - → GAP, except for the bad-length case, which → IDLE.
  - GAP: count GAP_CYC cycles, then → IDLE.
- Latency: req_valid seen in IDLE at cycle t → req_ready at t+1 → tx_start at t+2.
- Requester handshake rule: a requester holds valid, data and len stable until its req_ready pulse.
- Deasserting req_valid in the IDLE→GRANT cycle is illegal. The bench asserts this never happens.
- enable falling during GRANT/LAUNCH/WAIT/REPORT/GAP has no effect on that word. It only blocks the IDLE→GRANT transition.
- tx_done or tx_err arriving outside WAIT is ignored. Stray pulses are not counted.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 words.
- Counters: gap counter width clog2(GAP_CYC+1); timeout counter width clog2(TIMEOUT_CYC). Neither wraps; each is cleared on state entry.

Decomposition:
- Shared package sl_pkg holds:
  - the state enum (IDLE, GRANT, LAUNCH, WAIT, REPORT, GAP);
  - the done_err codes (ERR_OK, ERR_LEN, ERR_LINE, ERR_TIMEOUT);
  - SL_MIN_LEN=8, SL_MAX_LEN=32, SL_WORD_W=32.
- One sub-module, sl_rr_arbiter: combinational round-robin priority pick from req_valid and last_grant, producing a winner id and an any-valid flag.

Test Plan:
1. Single word: req_valid[0]=1, data 0xA5A5_0F0F, len 32 → req_ready[0] at t+1; tx_start at t+2 with tx_data=0xA5A5_0F0F, tx_len=32. Engine tx_done after 300 cycles → done_valid, id 0, err 0. Next tx_start is no earlier than GAP_CYC+2 cycles after tx_done.
2. Round robin: all 4 requesters valid continuously with lengths 8, 16, 24, 32 → grant order 0,1,2,3,0. Each tx_len matches its requester.
3. Bad lengths: req_len 7 and 33 on requester 2 → req_ready[2] pulses, no tx_start, done_err=1, back to IDLE in 3 cycles.
4. Engine faults: tx_err in WAIT → done_err=2. Engine silent → done_err=3 exactly TIMEOUT_CYC cycles after tx_start. Simultaneous tx_done+tx_err → done_err=2.
5. Enable/busy gating: enable=0 with requests pending → no req_ready. enable dropped mid-WAIT → word completes normally. tx_busy=1 in IDLE → no grant until it falls.
6. Mid-word reset: rst_n low for 1 cycle during WAIT → all outputs 0 next cycle. The next grant goes to requester 0 when its req_valid is set.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared state encoding, completion status codes and word-length limits
// for the serial-line transmit scheduler.
package sl_pkg;

    localparam int SL_WORD_W = 32;
    localparam int SL_LEN_W  = 6;

    localparam logic [SL_LEN_W-1:0] SL_MIN_LEN = 6'd8;
    localparam logic [SL_LEN_W-1:0] SL_MAX_LEN = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        WAIT,
        REPORT,
        GAP
    } sl_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_LINE    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } sl_err_e;

endpackage

// File: rtl/sl_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant,
// wrapping modulo NREQ.
module sl_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    int             idx;
    logic [IDW-1:0] idx_w;

    // Scan farthest-first so the nearest valid requester is the final assignment.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx   = (int'(last_grant) + k) % NREQ;
            idx_w = idx[IDW-1:0];
            if (req_valid[idx_w]) begin
                winner    = idx_w;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sl_tx_sched.sv
// Round-robin scheduler sharing one serial-line transmit engine among NREQ
// requesters, with launch supervision, timeout and an enforced idle gap.
//   state  | meaning
//   IDLE   | waiting for enable, a valid request and an idle engine
//   GRANT  | req_ready to the winner, capture and check its word
//   LAUNCH | tx_start pulse to the engine
//   WAIT   | engine in flight, watching done/err/timeout
//   REPORT | done_valid pulse with status
//   GAP    | enforced idle time on the line
module sl_tx_sched
    import sl_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int DATA_W      = 32,
    parameter  int GAP_CYC     = 64,
    parameter  int TIMEOUT_CYC = 4096,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*SL_LEN_W-1:0] req_len,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic [SL_LEN_W-1:0]      tx_len,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    input  logic                     tx_err,
    output logic [IDW-1:0]           grant_id,
    output logic                     done_valid,
    output logic [IDW-1:0]           done_id,
    output logic [1:0]               done_err,
    output logic                     sched_busy
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC);

    // The timeout fires on the edge where the WAIT counter steps to TIMEOUT_CYC-1,
    // placing the timeout report exactly TIMEOUT_CYC cycles after tx_start.
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 2);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(NREQ - 1);

    sl_state_e state_q, state_d;

    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic [NREQ-1:0]     req_ready_d;
    logic                tx_start_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic [SL_LEN_W-1:0] tx_len_d;
    logic [IDW-1:0]      grant_id_d;
    logic                done_valid_d;
    logic [IDW-1:0]      done_id_d;
    logic [1:0]          done_err_d;

    logic [IDW-1:0]      winner;
    logic                any_valid;

    logic [DATA_W-1:0]   data_arr [NREQ];
    logic [SL_LEN_W-1:0] len_arr  [NREQ];
    logic [DATA_W-1:0]   sel_data;
    logic [SL_LEN_W-1:0] sel_len;
    logic                len_ok;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
        assign len_arr[i]  = req_len[i*SL_LEN_W +: SL_LEN_W];
    end

    assign sel_data = data_arr[grant_id];
    assign sel_len  = len_arr[grant_id];
    assign len_ok   = (sel_len >= SL_MIN_LEN) && (sel_len <= SL_MAX_LEN);

    sl_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        req_ready_d  = '0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data;
        tx_len_d     = tx_len;
        grant_id_d   = grant_id;
        done_valid_d = 1'b0;
        done_id_d    = done_id;
        done_err_d   = done_err;

        case (state_q)
            IDLE: begin
                if (enable && any_valid && !tx_busy) begin
                    state_d             = GRANT;
                    grant_id_d          = winner;
                    req_ready_d[winner] = 1'b1;
                end
            end
            GRANT: begin
                last_grant_d = grant_id;
                if (len_ok) begin
                    state_d    = LAUNCH;
                    tx_start_d = 1'b1;
                    tx_data_d  = sel_data;
                    tx_len_d   = sel_len;
                    to_cnt_d   = '0;
                end else begin
                    state_d      = REPORT;
                    done_valid_d = 1'b1;
                    done_id_d    = grant_id;
                    done_err_d   = ERR_LEN;
                end
            end
            LAUNCH: begin
                state_d  = WAIT;
                to_cnt_d = '0;
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (tx_err || tx_done || (to_cnt_q == TO_LAST)) begin
                    state_d      = REPORT;
                    done_valid_d = 1'b1;
                    done_id_d    = grant_id;
                    if (tx_err)       done_err_d = ERR_LINE;
                    else if (tx_done) done_err_d = ERR_OK;
                    else              done_err_d = ERR_TIMEOUT;
                end
            end
            REPORT: begin
                if (done_err == ERR_LEN) begin
                    state_d = IDLE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_INIT;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            tx_len       <= '0;
            grant_id     <= '0;
            done_valid   <= 1'b0;
            done_id      <= '0;
            done_err     <= '0;
            sched_busy   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            req_ready    <= req_ready_d;
            tx_start     <= tx_start_d;
            tx_data      <= tx_data_d;
            tx_len       <= tx_len_d;
            grant_id     <= grant_id_d;
            done_valid   <= done_valid_d;
            done_id      <= done_id_d;
            done_err     <= done_err_d;
            sched_busy   <= (state_d != IDLE);
        end
    end

endmodule
